// File: rtl/csa_accumulator.sv
// csa_accumulator: streaming multi-operand accumulator.
// Each accepted operand is folded into a redundant sum/carry pair with a 3:2
// carry-save stage. On the packet's last beat the pair is resolved CHUNK bits
// per cycle by a carry-propagate adder. The result is then offered on a
// valid/ready output.
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   in_valid/in_ready     operand handshake; in_data operand, in_last end of packet
//   out_valid/out_ready   result handshake; out_data resolved sum mod 2^ACC_WIDTH
//   busy                  packet in progress (partial S/C, resolving, or result pending)
module csa_accumulator #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 24,
    parameter int unsigned CHUNK     = 8,
    parameter int unsigned SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 busy
);

    localparam int unsigned NCHUNK = (ACC_WIDTH + CHUNK - 1) / CHUNK;
    localparam int unsigned PAD_W  = NCHUNK * CHUNK;
    localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned SH_W   = $clog2(PAD_W) + 1;

    localparam logic [1:0] ST_ACCUM   = 2'd0;
    localparam logic [1:0] ST_RESOLVE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    logic [1:0]           state, state_n;
    logic [ACC_WIDTH-1:0] s, s_n;
    logic [ACC_WIDTH-1:0] c, c_n;
    logic [ACC_WIDTH-1:0] result, result_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic                 carry, carry_n;
    logic                 pending, pending_n;
    logic                 in_ready_n, out_valid_n, busy_n;
    logic [ACC_WIDTH-1:0] out_data_n;

    logic [ACC_WIDTH-1:0] x_sext, x_zext, x;
    logic                 beat;
    logic [PAD_W-1:0]     s_pad, c_pad;
    logic [SH_W-1:0]      shamt;
    logic [CHUNK-1:0]     s_slice, c_slice;
    logic [CHUNK:0]       chunk_sum;
    logic [ACC_WIDTH-1:0] chunk_bits;

    // Operand extension to accumulator width.
    assign x_sext = ACC_WIDTH'($signed(in_data));
    assign x_zext = ACC_WIDTH'(in_data);
    assign x      = (SIGNED != 0) ? x_sext : x_zext;
    assign beat   = in_valid & in_ready;

    // One CPA chunk. S/C are zero-padded so a partial top chunk needs no special case.
    // Bits of the top chunk above ACC_WIDTH fall off in the final truncation.
    always_comb begin
        s_pad      = PAD_W'(s);
        c_pad      = PAD_W'(c);
        shamt      = SH_W'(idx) * SH_W'(CHUNK);
        s_slice    = CHUNK'(s_pad >> shamt);
        c_slice    = CHUNK'(c_pad >> shamt);
        chunk_sum  = (CHUNK+1)'(s_slice) + (CHUNK+1)'(c_slice) + (CHUNK+1)'(carry);
        chunk_bits = ACC_WIDTH'(PAD_W'(chunk_sum[CHUNK-1:0]) << shamt);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACCUM;
            s         <= '0;
            c         <= '0;
            result    <= '0;
            idx       <= '0;
            carry     <= 1'b0;
            pending   <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            s         <= s_n;
            c         <= c_n;
            result    <= result_n;
            idx       <= idx_n;
            carry     <= carry_n;
            pending   <= pending_n;
            in_ready  <= in_ready_n;
            out_valid <= out_valid_n;
            out_data  <= out_data_n;
            busy      <= busy_n;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_n     = state;
        s_n         = s;
        c_n         = c;
        result_n    = result;
        idx_n       = idx;
        carry_n     = carry;
        pending_n   = pending;
        in_ready_n  = in_ready;
        out_valid_n = out_valid;
        out_data_n  = out_data;

        case (state)
            ST_ACCUM: begin
                if (beat) begin
                    s_n = s ^ c ^ x;
                    c_n = ((s & c) | (c & x) | (x & s)) << 1;
                    if (in_last) begin
                        state_n    = ST_RESOLVE;
                        idx_n      = '0;
                        carry_n    = 1'b0;
                        result_n   = '0;
                        pending_n  = 1'b0;
                        in_ready_n = 1'b0;
                    end else begin
                        pending_n = 1'b1;
                    end
                end
            end
            ST_RESOLVE: begin
                result_n = result | chunk_bits;
                carry_n  = chunk_sum[CHUNK];
                idx_n    = idx + IDX_W'(1);
                if (idx == IDX_W'(NCHUNK - 1)) begin
                    state_n     = ST_DONE;
                    idx_n       = '0;
                    carry_n     = 1'b0;
                    out_valid_n = 1'b1;
                    out_data_n  = result | chunk_bits;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_n     = ST_ACCUM;
                    s_n         = '0;
                    c_n         = '0;
                    out_valid_n = 1'b0;
                    out_data_n  = '0;
                    in_ready_n  = 1'b1;
                end
            end
            default: begin
                state_n     = ST_ACCUM;
                in_ready_n  = 1'b1;
                out_valid_n = 1'b0;
                out_data_n  = '0;
            end
        endcase

        busy_n = (state_n != ST_ACCUM) || pending_n;
    end

endmodule

// File: tb/tb_csa_accumulator.sv
// Bench for csa_accumulator: four instances (CHUNK 8 signed, CHUNK 8 unsigned,
// CHUNK 5, CHUNK 24) share one stimulus stream. Expected sums and latencies
// are queued per lane when the last beat is accepted and checked on transfer.
module tb_csa_accumulator;

    localparam int N = 4;
    localparam int unsigned CH  [N] = '{8, 8, 5, 24};
    localparam int unsigned SG  [N] = '{1, 0, 1, 1};
    localparam int          LAT [N] = '{3, 3, 5, 1};

    typedef struct {
        logic [23:0] s_sum;
        logic [23:0] u_sum;
        int          acc_cyc;
        bit          lat_chk;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic [15:0]   in_data;
    logic          in_last;
    logic          out_ready;
    logic [N-1:0]  in_ready_v;
    logic [N-1:0]  out_valid_v;
    logic [N-1:0]  busy_v;
    logic [23:0]   out_data_v [N];

    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [23:0] acc_s;
    logic [23:0] acc_u;
    bit          lat_chk;
    exp_t        sbq [N][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < N; g++) begin : lane
        exp_t        e;
        logic [23:0] want;

        csa_accumulator #(
            .WIDTH(16), .ACC_WIDTH(24), .CHUNK(CH[g]), .SIGNED(SG[g])
        ) dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[g]),
            .in_data   (in_data),
            .in_last   (in_last),
            .out_valid (out_valid_v[g]),
            .out_ready (out_ready),
            .out_data  (out_data_v[g]),
            .busy      (busy_v[g])
        );

        // Scoreboard pop on every result transfer.
        always @(negedge clk) begin
            if (rst_n && out_valid_v[g] && out_ready) begin
                checks++;
                assert (sbq[g].size() > 0) else begin
                    errors++;
                    $error("FAIL lane%0d_unexpected: out_data=%h with nothing expected", g, out_data_v[g]);
                end
                if (sbq[g].size() > 0) begin
                    e    = sbq[g].pop_front();
                    want = (SG[g] != 0) ? e.s_sum : e.u_sum;
                    checks++;
                    assert (out_data_v[g] === want) else begin
                        errors++;
                        $error("FAIL lane%0d_data: got %h want %h", g, out_data_v[g], want);
                    end
                    if (e.lat_chk) begin
                        checks++;
                        assert (cyc === e.acc_cyc + LAT[g]) else begin
                            errors++;
                            $error("FAIL lane%0d_latency: got %0d want %0d", g, cyc - e.acc_cyc, LAT[g]);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp();
        exp_t e;
        e.s_sum   = acc_s;
        e.u_sum   = acc_u;
        e.acc_cyc = cyc;
        e.lat_chk = lat_chk;
        for (int g = 0; g < N; g++) sbq[g].push_back(e);
    endtask

    // Offer one beat; called and returns at posedge+1.
    task automatic beat(input logic [15:0] d, input logic last, input bit record);
        checks++;
        assert (in_ready_v === 4'hF) else begin
            errors++;
            $error("FAIL in_ready_before_beat: got %b want %b", in_ready_v, 4'hF);
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = 16'h0;
        acc_s    = acc_s + {{8{d[15]}}, d};
        acc_u    = acc_u + {8'h00, d};
        if (last) begin
            if (record) push_exp();
            acc_s = '0;
            acc_u = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain_check(input string tag);
        for (int g = 0; g < N; g++) begin
            checks++;
            assert (sbq[g].size() == 0) else begin
                errors++;
                $error("FAIL %s_lane%0d_pending: got %0d results outstanding want 0", tag, g, sbq[g].size());
            end
        end
        checks++;
        assert (busy_v === 4'h0) else begin
            errors++;
            $error("FAIL %s_busy_idle: got %b want %b", tag, busy_v, 4'h0);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        for (int g = 0; g < N; g++) begin
            checks++;
            assert (in_ready_v[g] === 1'b1) else begin
                errors++; $error("FAIL %s_in_ready%0d: got %b want 1", tag, g, in_ready_v[g]);
            end
            checks++;
            assert (out_valid_v[g] === 1'b0) else begin
                errors++; $error("FAIL %s_out_valid%0d: got %b want 0", tag, g, out_valid_v[g]);
            end
            checks++;
            assert (out_data_v[g] === 24'h0) else begin
                errors++; $error("FAIL %s_out_data%0d: got %h want 000000", tag, g, out_data_v[g]);
            end
            checks++;
            assert (busy_v[g] === 1'b0) else begin
                errors++; $error("FAIL %s_busy%0d: got %b want 0", tag, g, busy_v[g]);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        acc_s     = '0;
        acc_u     = '0;

        // Reset state.
        idle(2);
        check_reset_vals("reset");
        rst_n = 1'b1;
        idle(1);

        // 1 + 2 + 3.
        beat(16'd1, 1'b0, 1'b1);
        checks++;
        assert (busy_v === 4'hF) else begin
            errors++; $error("FAIL busy_mid_packet: got %b want %b", busy_v, 4'hF);
        end
        beat(16'd2, 1'b0, 1'b1);
        beat(16'd3, 1'b1, 1'b1);
        idle(8);
        drain_check("sum123");

        // Carry across chunk boundary (unsigned: 0x010000, signed: 0).
        beat(16'hFFFF, 1'b0, 1'b1);
        beat(16'h0001, 1'b1, 1'b1);
        idle(8);
        drain_check("ffff_plus1");

        // Negative operands, then cancellation.
        beat(16'h8000, 1'b0, 1'b1);
        beat(16'h8000, 1'b0, 1'b1);
        beat(16'h8000, 1'b1, 1'b1);
        idle(8);
        beat(16'hFFFF, 1'b0, 1'b1);
        beat(16'h0001, 1'b1, 1'b1);
        idle(8);
        drain_check("neg");

        // Long packet, 300 x 0x7FFF.
        for (int i = 0; i < 300; i++) beat(16'h7FFF, (i == 299), 1'b1);
        idle(8);
        drain_check("long");

        // Backpressure in DONE with a beat offered.
        out_ready = 1'b0;
        lat_chk   = 1'b0;
        beat(16'h0100, 1'b0, 1'b1);
        beat(16'h0023, 1'b1, 1'b1);
        w = 0;
        while (out_valid_v !== 4'hF && w < 20) begin
            @(posedge clk);
            #1;
            w++;
        end
        checks++;
        assert (out_valid_v === 4'hF) else begin
            errors++; $error("FAIL bp_wait_valid: got %b want %b", out_valid_v, 4'hF);
        end
        in_valid = 1'b1;
        in_data  = 16'h0055;
        in_last  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            for (int g = 0; g < N; g++) begin
                checks++;
                assert (out_valid_v[g] === 1'b1) else begin
                    errors++; $error("FAIL bp_valid%0d: got %b want 1", g, out_valid_v[g]);
                end
                checks++;
                assert (in_ready_v[g] === 1'b0) else begin
                    errors++; $error("FAIL bp_in_ready%0d: got %b want 0", g, in_ready_v[g]);
                end
                checks++;
                assert (out_data_v[g] === 24'h000123) else begin
                    errors++; $error("FAIL bp_data%0d: got %h want 000123", g, out_data_v[g]);
                end
            end
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        assert (in_ready_v === 4'hF && out_valid_v === 4'h0) else begin
            errors++;
            $error("FAIL bp_after_xfer: in_ready=%b out_valid=%b want %b %b", in_ready_v, out_valid_v, 4'hF, 4'h0);
        end
        idle(4);
        drain_check("bp");
        lat_chk = 1'b1;
        beat(16'd5, 1'b0, 1'b1);
        beat(16'd7, 1'b1, 1'b1);
        idle(8);
        drain_check("after_bp");

        // Reset during the second resolve cycle discards the packet.
        out_ready = 1'b0;
        beat(16'h0042, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_reset");
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(1);
        beat(16'd9, 1'b1, 1'b1);
        idle(8);
        drain_check("post_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
